rr_grant_servicer: RTL and testbench
====================================

# rr_grant_servicer

Requester-side companion to the round-robin arbiter. Queues per-client transaction requests and drives the arbiter's `request` vector. Consumes its one-hot `grant`, runs a fixed-length burst for the granted client, and returns the `ack` that advances the arbiter's rotation. Sits between client logic and the arbiter; its `request`/`ack` outputs wire directly to the arbiter's `request`/`ack` inputs.

## Interface
- WIDTH, 4, number of clients; must match the arbiter's WIDTH; ≥2
- DEPTH, 3, maximum outstanding transactions per client; ≥1
- BEATS, 4, data beats per granted transfer; ≥1
- Derived widths: IW = $clog2(WIDTH); CW = $clog2(DEPTH+1); BW = max(1, $clog2(BEATS))

Ports:
- clk  in  1  single clock, rising edge
- resetb  in  1  reset, synchronous, active-high
- req_in  in  WIDTH  per-client new-transaction pulse, 1 cycle per transaction
- grant  in  WIDTH  grant from the arbiter; only one-hot values are valid
- request  out  WIDTH  to arbiter; request[i] = (pending[i] != 0)
- ack  out  1  to arbiter; 1-cycle pulse ending a transfer or forcing re-arbitration
- xfer_valid  out  1  a burst beat is active this cycle
- xfer_client  out  IW  index of the client being served
- xfer_beat  out  BW  beat number, 0..BEATS-1
- drop  out  WIDTH  1-cycle pulse: req_in[i] was discarded because pending[i]==DEPTH

## Operation
- Per-client counters pending[i], CW bits, range 0..DEPTH.
  - Increment on req_in[i].
  - Decrement on completion of client i's transfer.
  - Simultaneous increment and decrement: net unchanged; no drop, even at DEPTH.
  - req_in[i] at DEPTH without a same-cycle decrement: counter holds and drop[i]=1 next cycle.
- FSM states:
  - IDLE
    - grant is one-hot and pending[grant index] != 0 → BUSY; latch the client index and set beat=0.
    - Otherwise, if any pending != 0 → SKIP.
    - Otherwise stay in IDLE.
  - BUSY: xfer_valid=1; beat increments each cycle; after beat BEATS-1 → ACK.
  - ACK: ack=1; decrement pending[latched index]; → WAIT.
  - SKIP: ack=1, no decrement → WAIT. SKIP covers three cases:
    - grant==0 (bootstrap)
    - grant not one-hot
    - grant points to an idle client
  - WAIT: one dead cycle while the arbiter's registered grant updates; → IDLE.
- grant is sampled only in IDLE; changes during BUSY/ACK/WAIT are ignored.
- Index encoding: position of the single set bit of grant (bit 0 → 0).
- All outputs are registered or decoded from registered state.
- request reflects pending after that cycle's update, so it is valid one cycle after req_in.

## Timing
- Reset (resetb=1 at a clock edge), effective the next cycle:
  - state=IDLE
  - all pending=0
  - request=0, ack=0, xfer_valid=0, xfer_client=0, xfer_beat=0, drop=0
- Reset mid-burst aborts the burst: no ack is issued and queued work is lost.
- Transfer latency, with a valid grant seen in IDLE at cycle t:
  - xfer_valid=1 on cycles t+1..t+BEATS, xfer_beat=0..BEATS-1
  - ack=1 at t+BEATS+1
  - WAIT at t+BEATS+2
  - IDLE at t+BEATS+3, where grant is re-sampled
- Period per transfer: BEATS+3 cycles.
- Skip path: SKIP (ack) at t+1, WAIT at t+2, IDLE at t+3.
- ack is never high on two consecutive cycles; minimum spacing is 3 cycles.
- Between ack pulses, xfer_client is stable for the whole burst.

## Test plan
- Single client, WIDTH=4, BEATS=4:
  - Stimulus: reset; req_in=4'b0010 at cycle 2; arbiter grants 4'b0010.
  - Required: request=4'b0010 at cycle 3; SKIP path ack on the first idle grant (grant==0), then a burst with xfer_client=1, beats 0..3, then ack.
  - Required: pending[1]=0 after ack; request returns to 0.
- Round robin: one req_in each for clients 0..3 at the same cycle, connected to the arbiter.
  - Required: four bursts in the arbiter's rotation order, each BEATS+3 cycles apart.
  - Required: exactly four transfer acks, plus a single bootstrap skip ack.
- Overflow at DEPTH=3, no grant progress:
  - Stimulus: four req_in[2] pulses.
  - Required: pending[2]=3 and drop[2]=1 exactly once.
  - Stimulus: req_in[2] on the same cycle as client 2's ACK.
  - Required: pending stays 3, drop stays 0.
- Stale or invalid grant:
  - Stimulus: force grant=4'b0101, or a grant pointing at a client with pending=0, while another client is pending.
  - Required: SKIP ack, no xfer_valid, no pending change.
- Reset mid-burst:
  - Stimulus: assert resetb at beat 2.
  - Required: next cycle xfer_valid=0, ack=0, request=0, all pending=0; no ack ever follows for the aborted burst.
- Grant change during BUSY:
  - Stimulus: toggle grant to another client mid-burst.
  - Required: xfer_client unchanged; burst completes with the full BEATS beats.

Source files
------------

// File: rtl/rr_grant_servicer.sv
// Requester-side companion to the round-robin arbiter: queues per-client transactions,
// drives request, runs a fixed-length burst for each valid grant and returns ack.
module rr_grant_servicer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned BEATS = 4,
    localparam int unsigned IW = $clog2(WIDTH),
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] req_in,
    input  logic [WIDTH-1:0] grant,
    output logic [WIDTH-1:0] request,
    output logic             ack,
    output logic             xfer_valid,
    output logic [IW-1:0]    xfer_client,
    output logic [BW-1:0]    xfer_beat,
    output logic [WIDTH-1:0] drop
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StBusy = 3'd1;
    localparam logic [2:0] StAck  = 3'd2;
    localparam logic [2:0] StSkip = 3'd3;
    localparam logic [2:0] StWait = 3'd4;

    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
    localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

    logic [2:0]                state_q, state_d;
    logic [IW-1:0]             client_q, client_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [WIDTH-1:0][CW-1:0]  pending_q, pending_d;
    logic [WIDTH-1:0]          drop_q, drop_d;
    logic [WIDTH-1:0]          dec;
    logic [IW-1:0]             grant_idx;
    logic                      grant_onehot;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    assign grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            request[i] = (pending_q[i] != '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        client_d = client_q;
        beat_d   = beat_q;
        case (state_q)
            StIdle: begin
                if (grant_onehot && request[grant_idx]) begin
                    state_d  = StBusy;
                    client_d = grant_idx;
                    beat_d   = '0;
                end else if (|request) begin
                    // Bootstrap, malformed or stale grant: ack anyway so the arbiter rotates.
                    state_d = StSkip;
                end
            end
            StBusy: begin
                if (beat_q == LastBeat) begin
                    state_d = StAck;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            StAck, StSkip: state_d = StWait;
            StWait:        state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    // Same-cycle enqueue and completion cancel, so a full queue never drops then.
    always_comb begin
        pending_d = pending_q;
        drop_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec[i] = (state_q == StAck) && (client_q == IW'(i));
            if (req_in[i] && !dec[i]) begin
                if (pending_q[i] == DepthC) begin
                    drop_d[i] = 1'b1;
                end else begin
                    pending_d[i] = pending_q[i] + CW'(1);
                end
            end else if (dec[i] && !req_in[i]) begin
                pending_d[i] = pending_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            state_q   <= StIdle;
            client_q  <= '0;
            beat_q    <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            client_q  <= client_d;
            beat_q    <= beat_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign ack         = (state_q == StAck) || (state_q == StSkip);
    assign xfer_valid  = (state_q == StBusy);
    assign xfer_client = client_q;
    assign xfer_beat   = beat_q;
    assign drop        = drop_q;

endmodule

// File: tb/tb_rr_grant_servicer.sv
// Scoreboard bench for rr_grant_servicer: stimulus pushes expected acks/drops,
// a monitor pops and checks them as the DUT presents them.
module tb_rr_grant_servicer;

    localparam int W = 4;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       resetb = 1'b1;
    logic [3:0] req_in = '0;
    logic [3:0] man_grant = '0;
    logic [3:0] arb_grant;
    logic       arb_en = 1'b0;
    logic [3:0] grant;
    int         arb_ptr;

    logic [3:0] request;
    logic       ack;
    logic       xfer_valid;
    logic [1:0] xfer_client;
    logic [1:0] xfer_beat;
    logic [3:0] drop;

    always #5 clk = ~clk;

    assign grant = arb_en ? arb_grant : man_grant;

    rr_grant_servicer #(
        .WIDTH(4),
        .DEPTH(3),
        .BEATS(4)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .req_in     (req_in),
        .grant      (grant),
        .request    (request),
        .ack        (ack),
        .xfer_valid (xfer_valid),
        .xfer_client(xfer_client),
        .xfer_beat  (xfer_beat),
        .drop       (drop)
    );

    typedef struct {
        bit xfer;
        int client;
        int gap;
    } exp_t;

    exp_t       ack_exp[$];
    logic [3:0] drop_exp[$];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural round-robin arbiter: registered grant advances on ack.
    function automatic int rr_next(input logic [3:0] req, input int ptr);
        for (int k = 1; k <= W; k++) begin
            int j;
            j = (ptr + k) % W;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (resetb) begin
            arb_grant <= '0;
            arb_ptr   <= W - 1;
        end else if (ack && rr_next(request, arb_ptr) >= 0) begin
            arb_grant <= 4'(1 << rr_next(request, arb_ptr));
            arb_ptr   <= rr_next(request, arb_ptr);
        end
    end

    task automatic push_ack(input bit xfer, input int client, input int gap);
        exp_t e;
        e.xfer = xfer;
        e.client = client;
        e.gap = gap;
        ack_exp.push_back(e);
    endtask

    initial begin
        int cyc = 0;
        int beat_cnt = 0;
        int burst_client = 0;
        int last_ack = -1000;
        exp_t e;
        logic [3:0] d;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (resetb) begin
                beat_cnt = 0;
                last_ack = -1000;
            end else begin
                if (xfer_valid) begin
                    if (beat_cnt == 0) burst_client = int'(xfer_client);
                    chk("xfer_beat", int'(xfer_beat), beat_cnt);
                    chk("xfer_client_stable", int'(xfer_client), burst_client);
                    beat_cnt++;
                end
                if (ack) begin
                    chk("ack_expected", int'(ack_exp.size() != 0), 1);
                    if (last_ack > -1000) chk("ack_spacing_ge3", int'(cyc - last_ack >= 3), 1);
                    if (ack_exp.size() != 0) begin
                        e = ack_exp.pop_front();
                        if (e.xfer) begin
                            chk("burst_beats", beat_cnt, B);
                            chk("burst_client", burst_client, e.client);
                        end else begin
                            chk("skip_no_beats", beat_cnt, 0);
                        end
                        if (e.gap != 0) chk("ack_gap", cyc - last_ack, e.gap);
                    end
                    beat_cnt = 0;
                    last_ack = cyc;
                end
                if (drop != '0) begin
                    chk("drop_expected", int'(drop_exp.size() != 0), 1);
                    if (drop_exp.size() != 0) begin
                        d = drop_exp.pop_front();
                        chk("drop_vec", int'(drop), int'(d));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        resetb = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        @(negedge clk);
        req_in = v;
        @(negedge clk);
        req_in = '0;
    endtask

    task automatic wait_acks(input int n, input string name);
        int seen = 0;
        int budget = 100;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (ack) seen++;
            budget--;
        end
        chk(name, seen, n);
    endtask

    task automatic wait_beat(input int b, input string name);
        int found = 0;
        int budget = 100;
        while (found == 0 && budget > 0) begin
            @(negedge clk);
            if (xfer_valid && int'(xfer_beat) == b) found = 1;
            budget--;
        end
        chk(name, found, 1);
    endtask

    task automatic wait_drain(input string name);
        int budget = 300;
        while (ack_exp.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(name, ack_exp.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acks;
        repeat (2) @(negedge clk);
        chk("reset_request", int'(request), 0);
        chk("reset_ack", int'(ack), 0);
        chk("reset_xfer_valid", int'(xfer_valid), 0);
        chk("reset_xfer_client", int'(xfer_client), 0);
        chk("reset_xfer_beat", int'(xfer_beat), 0);
        chk("reset_drop", int'(drop), 0);
        resetb = 1'b0;

        // Single client through the arbiter: bootstrap skip, then burst for client 1.
        arb_en = 1'b1;
        push_ack(1'b0, 0, 0);
        push_ack(1'b1, 1, 7);
        pulse(4'b0010);
        chk("t1_request", int'(request), 2);
        wait_drain("t1_drain");
        chk("t1_request_idle", int'(request), 0);

        // All four clients at once: skip then rotation 0,1,2,3 every BEATS+3 cycles.
        do_reset();
        push_ack(1'b0, 0, 0);
        for (int c = 0; c < 4; c++) push_ack(1'b1, c, 7);
        pulse(4'b1111);
        chk("t2_request", int'(request), 15);
        wait_drain("t2_drain");
        chk("t2_request_idle", int'(request), 0);

        // Overflow: fourth pulse drops once; enqueue during ACK neither drops nor grows.
        arb_en = 1'b0;
        man_grant = 4'b0100;
        do_reset();
        drop_exp.push_back(4'b0100);
        push_ack(1'b1, 2, 0);
        for (int k = 0; k < 3; k++) push_ack(1'b1, 2, 7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_in = 4'b0100;
        end
        @(negedge clk);
        req_in = '0;
        wait_acks(1, "t3_first_ack");
        req_in = 4'b0100;
        @(negedge clk);
        req_in = '0;
        chk("t3_request", int'(request), 4);
        wait_drain("t3_drain");
        chk("t3_request_idle", int'(request), 0);
        chk("t3_drops_seen", drop_exp.size(), 0);

        // Malformed then stale grant skip; grant toggled mid-burst is ignored.
        man_grant = 4'b0101;
        do_reset();
        push_ack(1'b0, 0, 0);
        push_ack(1'b0, 0, 3);
        pulse(4'b1000);
        wait_acks(2, "t4_invalid_skips");
        man_grant = 4'b0001;
        push_ack(1'b0, 0, 3);
        push_ack(1'b0, 0, 3);
        wait_acks(2, "t4_stale_skips");
        chk("t4_request_kept", int'(request), 8);
        man_grant = 4'b1000;
        push_ack(1'b1, 3, 7);
        wait_beat(1, "t4_mid_burst");
        man_grant = 4'b0010;
        wait_drain("t4_drain");
        chk("t4_request_idle", int'(request), 0);

        // Reset at beat 2 aborts the burst with no ack.
        man_grant = 4'b0010;
        do_reset();
        pulse(4'b0010);
        wait_beat(2, "t5_beat2");
        resetb = 1'b1;
        @(negedge clk);
        chk("t5_xfer_valid", int'(xfer_valid), 0);
        chk("t5_ack", int'(ack), 0);
        chk("t5_request", int'(request), 0);
        chk("t5_drop", int'(drop), 0);
        chk("t5_xfer_client", int'(xfer_client), 0);
        chk("t5_xfer_beat", int'(xfer_beat), 0);
        resetb = 1'b0;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("t5_no_ack", acks, 0);
        chk("t5_request_idle", int'(request), 0);

        chk("ack_queue_empty", ack_exp.size(), 0);
        chk("drop_queue_empty", drop_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
